// File: rtl/rr_adder_scheduler.sv
// rr_adder_scheduler: round-robin arbitration of n_ch operand pairs onto one adder,
// results queued in a 2-entry in-order buffer. Optional macro: ADDER_SCHED_SAT_EN.
module rr_adder_scheduler #(
  parameter  int unsigned width = 8,
  parameter  int unsigned n_ch  = 4,
  localparam int unsigned idx_w = $clog2(n_ch)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [n_ch-1:0]         req_valid,
  output logic [n_ch-1:0]         req_ready,
  input  logic [n_ch*width-1:0]   req_a,
  input  logic [n_ch*width-1:0]   req_b,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [width-1:0]        sum_data,
  output logic [idx_w-1:0]        sum_ch
);

  logic [idx_w-1:0] ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             up_ready;
  logic [width-1:0] slot1_data;
  logic [idx_w-1:0] slot1_ch;

  logic             grant_found;
  logic [idx_w-1:0] grant_idx;
  logic [idx_w-1:0] cand;
  logic             accept;
  logic             pop;
  logic [width-1:0] op_a;
  logic [width-1:0] op_b;
  logic [width:0]   sum_full;
  logic [width-1:0] sum_val;

  // First valid channel at or after ptr, wrapping modulo n_ch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < n_ch; k++) begin
      cand = (32'(ptr) + k >= n_ch) ? idx_w'(32'(ptr) + k - n_ch) : idx_w'(32'(ptr) + k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found && up_ready) req_ready[grant_idx] = 1'b1;
  end

  assign accept   = grant_found & up_ready;
  assign pop      = sum_valid & sum_ready;
  assign op_a     = req_a[32'(grant_idx)*width +: width];
  assign op_b     = req_b[32'(grant_idx)*width +: width];
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_SCHED_SAT_EN
  assign sum_val = sum_full[width] ? {width{1'b1}} : sum_full[width-1:0];
`else
  assign sum_val = sum_full[width-1:0];
`endif

  always_comb begin
    count_next = count;
    case ({accept, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Head entry drives the sum_* outputs directly; slot1 holds the second entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      count      <= '0;
      up_ready   <= 1'b0;
      sum_valid  <= 1'b0;
      sum_data   <= '0;
      sum_ch     <= '0;
      slot1_data <= '0;
      slot1_ch   <= '0;
    end else begin
      count     <= count_next;
      up_ready  <= (count_next != 2'd2);
      sum_valid <= (count_next != 2'd0);
      if (accept) begin
        ptr <= (32'(grant_idx) == n_ch - 1) ? '0 : grant_idx + idx_w'(1);
      end
      if (pop) begin
        if (accept && count == 2'd1) begin
          sum_data <= sum_val;
          sum_ch   <= grant_idx;
        end else begin
          sum_data <= slot1_data;
          sum_ch   <= slot1_ch;
        end
      end else if (accept) begin
        if (count == 2'd0) begin
          sum_data <= sum_val;
          sum_ch   <= grant_idx;
        end else begin
          slot1_data <= sum_val;
          slot1_ch   <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_adder_scheduler.sv
// Scoreboard bench for rr_adder_scheduler: reference model pushes expected results,
// an independent monitor pops and compares them as the DUT presents output.
module tb_rr_adder_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           sum_valid;
  logic           sum_ready;
  logic [W-1:0]   sum_data;
  logic [1:0]     sum_ch;

  rr_adder_scheduler #(.width(W), .n_ch(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_data(sum_data), .sum_ch(sum_ch)
  );

  typedef struct {
    int ch;
    int data;
  } result_t;

  result_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic int ref_sum(input int a, input int b);
    int s;
    s = a + b;
`ifdef ADDER_SCHED_SAT_EN
    if (s > 255) s = 255;
`else
    s = s % 256;
`endif
    return s;
  endfunction

  // Reference model: occupancy, pointer and readiness tracked as plain integers.
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_armed = 0;
  int m_g;
  bit m_found;
  bit m_acc;
  bit m_pop;
  int m_c;
  logic [N-1:0] m_exp_rdy;
  result_t m_e;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_sum_valid", 32'(sum_valid), 32'd0);
      check("rst_sum_data", 32'(sum_data), 32'd0);
      check("rst_sum_ch", 32'(sum_ch), 32'd0);
      m_ptr = 0;
      m_cnt = 0;
      m_armed = 0;
      exp_q.delete();
    end else begin
      m_found = 0;
      m_g = 0;
      for (int k = 0; k < N; k++) begin
        m_c = (m_ptr + k) % N;
        if (!m_found && req_valid[m_c]) begin
          m_found = 1;
          m_g = m_c;
        end
      end
      m_acc = m_found && m_armed && (m_cnt < 2);
      m_exp_rdy = '0;
      if (m_acc) m_exp_rdy[m_g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(m_exp_rdy));
      check("sum_valid", 32'(sum_valid), 32'(m_cnt != 0));
      m_pop = (m_cnt != 0) && sum_ready;
      if (m_acc) begin
        m_e.ch = m_g;
        m_e.data = ref_sum(int'(req_a[m_g*W +: W]), int'(req_b[m_g*W +: W]));
        exp_q.push_back(m_e);
        m_ptr = (m_g + 1) % N;
      end
      m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
      m_armed = 1;
    end
  end

  // Monitor: pops on every output handshake, checks stability under backpressure.
  bit         stall = 0;
  logic [7:0] hold_d;
  logic [1:0] hold_ch;
  result_t    mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      stall = 0;
    end else begin
      if (stall) begin
        check("hold_valid", 32'(sum_valid), 32'd1);
        check("hold_data", 32'(sum_data), 32'(hold_d));
        check("hold_ch", 32'(sum_ch), 32'(hold_ch));
      end
      if (sum_valid && sum_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got data %0d ch %0d with empty scoreboard at %0t",
                   sum_data, sum_ch, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sum_data", 32'(sum_data), 32'(mon_e.data));
          check("sum_ch", 32'(sum_ch), 32'(mon_e.ch));
        end
      end
      stall = sum_valid && !sum_ready;
      hold_d = sum_data;
      hold_ch = sum_ch;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '1;
    sum_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) set_ops(i, i, 10);
    step(3);
    rst = 1'b1;

    // All channels valid: grants rotate starting at ch0.
    step(12);

    // Single channel ch2.
    req_valid = 4'b0100;
    set_ops(2, 3, 4);
    step(4);
    req_valid = '0;
    step(2);

    // Backpressure then drain.
    for (int i = 0; i < N; i++) set_ops(i, i, 10);
    req_valid = '1;
    sum_ready = 1'b0;
    step(6);
    sum_ready = 1'b1;
    step(8);

    // Overflow corners.
    req_valid = 4'b0010;
    set_ops(1, 200, 100);
    step(2);
    req_valid = 4'b1000;
    set_ops(3, 255, 1);
    step(2);
    req_valid = '0;
    step(2);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_ops(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      sum_ready = ($urandom_range(0, 9) < 7);
      step(1);
    end

    // Reset with the buffer full.
    req_valid = '1;
    sum_ready = 1'b0;
    step(4);
    rst = 1'b0;
    #1;
    check("midrst_sum_valid", 32'(sum_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    step(2);
    rst = 1'b1;
    sum_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 50, i);
    step(10);
    req_valid = '0;
    step(5);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
